div_issue: RTL

Multi-cycle divide issue/retire controller sitting between the EX stage and the iterative divider. Accepts DIV/DIVU from EX, drives the divider's start/annul handshake, stalls the pipeline until the quotient/remainder arrive, and produces a one-cycle HI/LO write. Handles exception flushes mid-divide so the divider always returns to idle before the next issue.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_fast_path.sv | 29 ++
 rtl/div_issue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types for the divide issue/retire controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } div_state_t;

  localparam int ABORT_CYCLES = 2;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } div_result_t;

endpackage

// File: rtl/div_fast_path.sv
// Trivial-divide detection (x/0, x/1, unsigned small/large); exists only when
// DIV_FAST_PATH_EN is defined.
`ifdef DIV_FAST_PATH_EN
module div_fast_path
  import div_pkg::*;
(
  input  logic        sgn,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        hit,
  output div_result_t res
);

  always_comb begin
    hit = 1'b0;
    res = '0;
    if (op2 == 32'd0) begin
      hit = 1'b1;
    end else if (op2 == 32'd1) begin
      hit    = 1'b1;
      res.lo = op1;
    end else if (!sgn && (op1 < op2)) begin
      hit    = 1'b1;
      res.hi = op1;
    end
  end

endmodule
`endif

// File: rtl/div_issue.sv
// Divide issue/retire controller between EX and the iterative divider.
// Optional trivial-case bypass enabled by defining DIV_FAST_PATH_EN.
//
// state | meaning
// IDLE  | waiting for a DIV/DIVU in EX
// BUSY  | divider running, start held high until ready
// DONE  | result captured, one-cycle HI/LO write unless flushed
// ABORT | annul held for ABORT_CYCLES so the divider returns to idle
module div_issue
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_op1_i,
  input  logic [31:0] ex_op2_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i
);

  localparam logic ABORT_LAST = 1'(ABORT_CYCLES - 1);

  div_state_t  state;
  logic        abort_cnt;
  logic        issue;
  logic        fast_hit;
  div_result_t fast_res;
  div_result_t div_res;

`ifdef DIV_FAST_PATH_EN
  div_fast_path u_fast_path (
    .sgn (ex_signed_i),
    .op1 (ex_op1_i),
    .op2 (ex_op2_i),
    .hit (fast_hit),
    .res (fast_res)
  );
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  assign div_res   = div_result_i;
  assign issue     = (state == IDLE) && ex_div_valid_i && !flush_i;
  assign hilo_we_o = (state == DONE) && !flush_i;

  // A new divide arriving during ABORT must wait until the divider is clean.
  always_comb begin
    stall_req_o = 1'b0;
    case (state)
      IDLE:    stall_req_o = issue;
      BUSY:    stall_req_o = 1'b1;
      DONE:    stall_req_o = 1'b0;
      ABORT:   stall_req_o = ex_div_valid_i;
      default: stall_req_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      abort_cnt    <= 1'b0;
      div_start_o  <= 1'b0;
      div_annul_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            div_signed_o <= ex_signed_i;
            div_op1_o    <= ex_op1_i;
            div_op2_o    <= ex_op2_i;
            if (fast_hit) begin
              hi_o  <= fast_res.hi;
              lo_o  <= fast_res.lo;
              state <= DONE;
            end else begin
              div_start_o <= 1'b1;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          // Flush wins over a coincident ready: the result is discarded.
          if (flush_i) begin
            div_start_o <= 1'b0;
            div_annul_o <= 1'b1;
            abort_cnt   <= 1'b0;
            state       <= ABORT;
          end else if (div_ready_i) begin
            hi_o        <= div_res.hi;
            lo_o        <= div_res.lo;
            div_start_o <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ABORT: begin
          if (abort_cnt == ABORT_LAST) begin
            div_annul_o <= 1'b0;
            state       <= IDLE;
          end else begin
            abort_cnt <= abort_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
